// File: rtl/player_bullet_manager.sv
// Player bullet pool: spawns, advances once per frame and retires bullets; kill flags come back from collision.
// Optional double shot, two bullets per spawn, is enabled by defining PLAYER_BULLET_DOUBLE_SHOT_EN.
module player_bullet_manager #(
    parameter int          MAX_PLAYER_BULLET = 8,
    parameter int          BULLET_WIDTH      = 4,
    parameter int          BULLET_HEIGHT     = 8,
    parameter int          BULLET_SPEED      = 4,
    parameter int          PLAYER_WIDTH      = 32,
    parameter int          PLAYER_CENTER_Y   = 440,
    parameter int          FIRE_COOLDOWN     = 8,
    parameter logic [18:0] NONE              = 19'h7FFFF
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Rst_n,
    input  logic                                       i_FrameTick,
    input  logic                                       i_Fire,
    input  logic                                       i_PlayerState,
    input  logic [9:0]                                 i_PlayerPosition,
    input  logic [MAX_PLAYER_BULLET-1:0]               i_KillMask,
    output logic [MAX_PLAYER_BULLET-1:0]               o_PlayerBulletState,
    output logic [19*MAX_PLAYER_BULLET-1:0]            o_PlayerBulletPosition,
    output logic                                       o_FireAccepted,
    output logic [$clog2(MAX_PLAYER_BULLET+1)-1:0]     o_ActiveCount,
    output logic                                       o_Busy
);

    localparam int CNT_W = $clog2(MAX_PLAYER_BULLET + 1);
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);
    localparam int IDX_W = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;

    localparam logic [9:0] CENTER_OFFSET = 10'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
    localparam logic [8:0] SPAWN_Y       = 9'(PLAYER_CENTER_Y - BULLET_HEIGHT);
    localparam logic [8:0] SPEED_Y       = 9'(BULLET_SPEED);
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
    localparam logic [9:0] RIGHT_OFFSET  = 10'(PLAYER_WIDTH - BULLET_WIDTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KILL  = 2'd1,
        S_MOVE  = 2'd2,
        S_SPAWN = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [MAX_PLAYER_BULLET-1:0]        bullet_state_q, bullet_state_d;
    logic [MAX_PLAYER_BULLET-1:0][18:0]  bullet_pos_q, bullet_pos_d;
    logic [MAX_PLAYER_BULLET-1:0]        kill_mask_q, kill_mask_d;
    logic [CD_W-1:0]                     cooldown_q, cooldown_d;
    logic                                fire_latch_q, fire_latch_d;
    logic                                fire_accepted_q, fire_accepted_d;
    logic [CNT_W-1:0]                    active_count_q, active_count_d;

    logic                                frame_start;
    logic                                kill_phase;
    logic                                move_phase;
    logic                                spawn_phase;
    logic                                busy;

    logic [IDX_W-1:0]                    first_free;
    logic                                have_free;
    logic [9:0]                          center_x;
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
    logic [IDX_W-1:0]                    second_free;
    logic                                have_two;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tick outside S_IDLE is dropped, never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_FrameTick) state_d = S_KILL;
            S_KILL:  state_d = S_MOVE;
            S_MOVE:  state_d = S_SPAWN;
            S_SPAWN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_start = (state_q == S_IDLE) && i_FrameTick;
        kill_phase  = (state_q == S_KILL);
        move_phase  = (state_q == S_MOVE);
        spawn_phase = (state_q == S_SPAWN);
        busy        = (state_q != S_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bullet_state_q  <= '0;
            bullet_pos_q    <= {MAX_PLAYER_BULLET{NONE}};
            kill_mask_q     <= '0;
            cooldown_q      <= '0;
            fire_latch_q    <= 1'b0;
            fire_accepted_q <= 1'b0;
            active_count_q  <= '0;
        end else begin
            bullet_state_q  <= bullet_state_d;
            bullet_pos_q    <= bullet_pos_d;
            kill_mask_q     <= kill_mask_d;
            cooldown_q      <= cooldown_d;
            fire_latch_q    <= fire_latch_d;
            fire_accepted_q <= fire_accepted_d;
            active_count_q  <= active_count_d;
        end
    end

    // Free-slot search runs on the registered vector, which already reflects this frame's kills and moves.
    always_comb begin
        first_free = '0;
        have_free  = 1'b0;
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
        second_free = '0;
        have_two    = 1'b0;
`endif
        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            if (!bullet_state_q[k]) begin
                if (!have_free) begin
                    first_free = IDX_W'(k);
                    have_free  = 1'b1;
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
                end else if (!have_two) begin
                    second_free = IDX_W'(k);
                    have_two    = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        bullet_state_d  = bullet_state_q;
        bullet_pos_d    = bullet_pos_q;
        kill_mask_d     = kill_mask_q;
        cooldown_d      = cooldown_q;
        fire_latch_d    = fire_latch_q | i_Fire;
        fire_accepted_d = 1'b0;
        center_x        = i_PlayerPosition + CENTER_OFFSET;

        if (frame_start) begin
            kill_mask_d = i_KillMask;
        end

        if (kill_phase) begin
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                if (bullet_state_q[k] && kill_mask_q[k]) begin
                    bullet_state_d[k] = 1'b0;
                    bullet_pos_d[k]   = NONE;
                end
            end
        end

        if (move_phase) begin
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                if (bullet_state_q[k]) begin
                    if (bullet_pos_q[k][8:0] < SPEED_Y) begin
                        bullet_state_d[k] = 1'b0;
                        bullet_pos_d[k]   = NONE;
                    end else begin
                        bullet_pos_d[k][8:0] = bullet_pos_q[k][8:0] - SPEED_Y;
                    end
                end
            end
            if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 1'b1;
            end
        end

        // The latch is consumed every spawn phase, so a blocked request never carries into the next frame.
        if (spawn_phase) begin
            fire_latch_d = 1'b0;
            if (fire_latch_q && (cooldown_q == '0) && i_PlayerState && have_free) begin
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
                if (have_two) begin
                    bullet_state_d[first_free]  = 1'b1;
                    bullet_pos_d[first_free]    = {i_PlayerPosition, SPAWN_Y};
                    bullet_state_d[second_free] = 1'b1;
                    bullet_pos_d[second_free]   = {i_PlayerPosition + RIGHT_OFFSET, SPAWN_Y};
                end else begin
                    bullet_state_d[first_free] = 1'b1;
                    bullet_pos_d[first_free]   = {center_x, SPAWN_Y};
                end
`else
                bullet_state_d[first_free] = 1'b1;
                bullet_pos_d[first_free]   = {center_x, SPAWN_Y};
`endif
                cooldown_d      = CD_W'(FIRE_COOLDOWN);
                fire_accepted_d = 1'b1;
            end
        end

        active_count_d = '0;
        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            active_count_d = active_count_d + CNT_W'(bullet_state_d[k]);
        end
    end

    assign o_PlayerBulletState    = bullet_state_q;
    assign o_PlayerBulletPosition = bullet_pos_q;
    assign o_FireAccepted         = fire_accepted_q;
    assign o_ActiveCount          = active_count_q;
    assign o_Busy                 = busy;

endmodule

// File: tb/tb_player_bullet_manager.sv
// Self-checking bench for player_bullet_manager: directed scenarios plus randomized frames against a slot-pool model.
module tb_player_bullet_manager;

    localparam int N        = 8;
    localparam int CNT_W    = $clog2(N + 1);
    localparam int SPEED    = 4;
    localparam int COOLDOWN = 8;
    localparam int SPAWN_Y  = 440 - 8;
    localparam int CENTER   = (32 - 4) / 2;
    localparam int RIGHT    = 32 - 4;

    logic               clk = 1'b0;
    logic               i_Rst_n;
    logic               i_FrameTick;
    logic               i_Fire;
    logic               i_PlayerState;
    logic [9:0]         i_PlayerPosition;
    logic [N-1:0]       i_KillMask;
    logic [N-1:0]       o_PlayerBulletState;
    logic [19*N-1:0]    o_PlayerBulletPosition;
    logic               o_FireAccepted;
    logic [CNT_W-1:0]   o_ActiveCount;
    logic               o_Busy;

    player_bullet_manager dut (
        .i_Clk                  (clk),
        .i_Rst_n                (i_Rst_n),
        .i_FrameTick            (i_FrameTick),
        .i_Fire                 (i_Fire),
        .i_PlayerState          (i_PlayerState),
        .i_PlayerPosition       (i_PlayerPosition),
        .i_KillMask             (i_KillMask),
        .o_PlayerBulletState    (o_PlayerBulletState),
        .o_PlayerBulletPosition (o_PlayerBulletPosition),
        .o_FireAccepted         (o_FireAccepted),
        .o_ActiveCount          (o_ActiveCount),
        .o_Busy                 (o_Busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference pool: per-slot activity and coordinates as plain integers.
    bit m_act[N];
    int m_x[N];
    int m_y[N];
    int m_cd;
    bit m_latch;
    bit m_accept;
    bit dut_accept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < N; k++) c += m_act[k];
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 1'b0;
            m_x[k]   = 0;
            m_y[k]   = 0;
        end
        m_cd     = 0;
        m_latch  = 1'b0;
        m_accept = 1'b0;
    endtask

    task automatic model_frame(input logic [N-1:0] mask, input bit fire, input int px, input bit alive);
        int fq[$];
        m_latch  = m_latch | fire;
        m_accept = 1'b0;
        for (int k = 0; k < N; k++)
            if (m_act[k] && mask[k]) m_act[k] = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
                if (m_y[k] < SPEED) m_act[k] = 1'b0;
                else m_y[k] = m_y[k] - SPEED;
            end
        end
        if (m_cd > 0) m_cd--;
        for (int k = 0; k < N; k++)
            if (!m_act[k]) fq.push_back(k);
        if (m_latch && m_cd == 0 && alive && fq.size() > 0) begin
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
            if (fq.size() >= 2) begin
                m_act[fq[0]] = 1'b1; m_x[fq[0]] = px % 1024;           m_y[fq[0]] = SPAWN_Y;
                m_act[fq[1]] = 1'b1; m_x[fq[1]] = (px + RIGHT) % 1024; m_y[fq[1]] = SPAWN_Y;
            end else begin
                m_act[fq[0]] = 1'b1; m_x[fq[0]] = (px + CENTER) % 1024; m_y[fq[0]] = SPAWN_Y;
            end
`else
            m_act[fq[0]] = 1'b1; m_x[fq[0]] = (px + CENTER) % 1024; m_y[fq[0]] = SPAWN_Y;
`endif
            m_cd     = COOLDOWN;
            m_accept = 1'b1;
        end
        m_latch = 1'b0;
    endtask

    task automatic check_output(input string tag);
        logic [18:0] exp_pos;
        for (int k = 0; k < N; k++) begin
            exp_pos = m_act[k] ? {10'(m_x[k]), 9'(m_y[k])} : 19'h7FFFF;
            check($sformatf("%s_slot%0d_state", tag, k), 32'(o_PlayerBulletState[k]), 32'(m_act[k]));
            check($sformatf("%s_slot%0d_pos", tag, k), 32'(o_PlayerBulletPosition[19*k +: 19]), 32'(exp_pos));
        end
        check({tag, "_count"}, 32'(o_ActiveCount), 32'(model_count()));
        check({tag, "_busy"}, 32'(o_Busy), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (i_Fire) m_latch = 1'b1;
        end
    endtask

    task automatic apply_reset();
        i_Rst_n     = 1'b0;
        i_Fire      = 1'b0;
        i_FrameTick = 1'b0;
        i_KillMask  = '0;
        @(posedge clk); #1;
        i_Rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    // One full frame: tick edge, KILL, MOVE, SPAWN, then one extra edge to see the accept pulse end.
    task automatic apply_stimulus(input logic [N-1:0] mask, input bit extra_tick, input bit scramble,
                                  input bit drop_fire);
        bit fire_f;
        fire_f      = i_Fire;
        i_KillMask  = mask;
        i_FrameTick = 1'b1;
        @(posedge clk); #1;
        check("busy_after_tick", 32'(o_Busy), 32'd1);
        i_FrameTick = extra_tick;
        if (scramble) i_KillMask = N'($urandom);
        @(posedge clk); #1;
        i_FrameTick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_frame(mask, fire_f, int'(i_PlayerPosition), i_PlayerState);
        dut_accept = o_FireAccepted;
        check_output("frame");
        check("fire_accepted", 32'(o_FireAccepted), 32'(m_accept));
        if (drop_fire) i_Fire = 1'b0;
        @(posedge clk); #1;
        check("fire_pulse_end", 32'(o_FireAccepted), 32'd0);
        m_latch = i_Fire;
    endtask

    initial begin
        logic [31:0] acc_ticks;
        logic [9:0]  exp_x;

        i_Rst_n          = 1'b0;
        i_FrameTick      = 1'b0;
        i_Fire           = 1'b0;
        i_PlayerState    = 1'b1;
        i_PlayerPosition = 10'd0;
        i_KillMask       = '0;
        model_reset();
        #12;
        check_output("reset");
        check("reset_accept", 32'(o_FireAccepted), 32'd0);
        @(posedge clk); #1;
        i_Rst_n = 1'b1;
        idle(2);

        $display("[TB] single fire pulse at x=100");
        i_PlayerPosition = 10'd100;
        i_Fire = 1'b1;
        idle(1);
        i_Fire = 1'b0;
        idle(2);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
`ifdef PLAYER_BULLET_DOUBLE_SHOT_EN
        exp_x = 10'd100;
`else
        exp_x = 10'd114;
`endif
        check("first_spawn_pos", 32'(o_PlayerBulletPosition[18:0]), 32'({exp_x, 9'd432}));
        check("first_spawn_accept", 32'(dut_accept), 32'd1);
        idle(1);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check("first_move_pos", 32'(o_PlayerBulletPosition[18:0]), 32'({exp_x, 9'd428}));

        $display("[TB] fire held for 20 ticks");
        apply_reset();
        i_Fire = 1'b1;
        idle(2);
        acc_ticks = '0;
        for (int t = 1; t <= 20; t++) begin
            apply_stimulus('0, 1'b0, 1'b0, 1'b0);
            acc_ticks[t] = dut_accept;
            idle(1);
        end
        check("held_fire_ticks", acc_ticks, 32'h0002_0202);

        $display("[TB] kill slot 1 with fire pending");
        i_Fire = 1'b0;
        idle(1);
        for (int t = 0; t < 6; t++) begin
            apply_stimulus('0, 1'b0, 1'b0, 1'b0);
            idle(1);
        end
        i_PlayerPosition = 10'd300;
        i_Fire = 1'b1;
        idle(1);
        i_Fire = 1'b0;
        idle(1);
        apply_stimulus(8'b0000_0010, 1'b0, 1'b1, 1'b0);
`ifndef PLAYER_BULLET_DOUBLE_SHOT_EN
        check("kill_respawn_count", 32'(o_ActiveCount), 32'd3);
        check("kill_respawn_pos", 32'(o_PlayerBulletPosition[19 +: 19]), 32'({10'd314, 9'd432}));
`endif

        $display("[TB] reset during MOVE");
        idle(1);
        i_FrameTick = 1'b1;
        @(posedge clk); #1;
        i_FrameTick = 1'b0;
        @(posedge clk); #1;
        i_Rst_n = 1'b0;
        #2;
        model_reset();
        check_output("async_reset");
        check("async_reset_accept", 32'(o_FireAccepted), 32'd0);
        @(posedge clk); #1;
        i_Rst_n = 1'b1;
        idle(1);

        $display("[TB] bullet lifetime to top of screen");
        i_PlayerPosition = 10'd500;
        i_Fire = 1'b1;
        idle(1);
        i_Fire = 1'b0;
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 108; t++) apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check("top_y_zero", 32'(o_PlayerBulletPosition[8:0]), 32'd0);
        check("top_still_active", 32'(o_PlayerBulletState[0]), 32'd1);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check("top_retired_state", 32'(o_PlayerBulletState[0]), 32'd0);
        check("top_retired_pos", 32'(o_PlayerBulletPosition[18:0]), 32'h7FFFF);

        $display("[TB] full pool and dead player");
        apply_reset();
        i_PlayerPosition = 10'd40;
        i_Fire = 1'b1;
        idle(1);
        for (int t = 0; t < 80 && model_count() < N; t++) apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check("pool_full_count", 32'(o_ActiveCount), 32'(N));
        for (int t = 0; t < 10; t++) begin
            apply_stimulus('0, 1'b0, 1'b0, 1'b0);
            check("pool_full_no_accept", 32'(dut_accept), 32'd0);
        end
        apply_stimulus(8'b0000_1000, 1'b0, 1'b0, 1'b0);
        i_PlayerState = 1'b0;
        apply_stimulus(8'b0011_0000, 1'b0, 1'b0, 1'b1);
        check("dead_no_accept", 32'(dut_accept), 32'd0);
        i_PlayerState = 1'b1;
        idle(1);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check("latch_cleared_no_accept", 32'(dut_accept), 32'd0);

        $display("[TB] randomized frames");
        for (int t = 0; t < 150; t++) begin
            i_PlayerPosition = 10'($urandom_range(0, 1023));
            i_PlayerState    = ($urandom_range(0, 9) != 0);
            i_Fire           = 1'($urandom_range(0, 1));
            idle($urandom_range(1, 3));
            apply_stimulus(N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
